// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// sys_defs : shared widths, defaults and bus types for the CDB arbiter slice
// Rev 1.0
// ============================================================================
`default_nettype none

package sys_defs;

  localparam int XLEN       = 32;
  localparam int TAG_SIZE   = 6;
  localparam int NUM_FU_MAX = 8;
  localparam int FU_ID_W    = $clog2(NUM_FU_MAX);

  localparam int NUM_FU_DEFAULT     = 5;
  localparam int NUM_CDB_DEFAULT    = 2;
  localparam int FIFO_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic                valid;
    logic                clear;
    logic [TAG_SIZE-1:0] tag;
    logic [XLEN-1:0]     value;
    logic                branch_taken;
    logic [FU_ID_W-1:0]  fu_id;
  } CDB_OUTPUT;

  typedef struct packed {
    logic [TAG_SIZE-1:0] tag;
    logic [XLEN-1:0]     value;
    logic                branch_taken;
  } CDB_ENTRY;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_fu_fifo.sv
// ============================================================================
// cdb_fu_fifo : per-FU result buffer, any depth >= 1, flushed by squash
// Rev 1.0
// ============================================================================
`default_nettype none

module cdb_fu_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     squash,
  input  logic     push_valid,
  input  CDB_ENTRY push_data,
  input  logic     pop,
  output logic     ready,
  output logic     not_empty,
  output CDB_ENTRY head
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  CDB_ENTRY         r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Ready looks only at the stored count, never at this cycle's pop.
  assign ready     = (r_count < C_DEPTH);
  assign not_empty = (r_count != '0);
  assign w_push    = push_valid && ready && !squash;
  assign w_pop     = pop && not_empty && !squash;
  assign head      = r_mem[r_head];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= (r_tail == C_LAST) ? '0 : r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= (r_head == C_LAST) ? '0 : r_head + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_tail] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : buffers FU results and grants up to NUM_CDB broadcast lanes
// Rev 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU     = NUM_FU_DEFAULT,
  parameter int NUM_CDB    = NUM_CDB_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int FIXED_PRIO = 0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               squash,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  logic [NUM_FU-1:0][TAG_SIZE-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_value,
  input  logic [NUM_FU-1:0]                  fu_take_branch,
  output logic [NUM_FU-1:0]                  fu_ready,
  output CDB_OUTPUT [NUM_CDB-1:0]            cdb_out
);

  localparam int IDX_W  = idx_width(NUM_FU);
  localparam int LANE_W = idx_width(NUM_CDB);
  localparam logic [IDX_W:0]   C_NUM_FU  = (IDX_W + 1)'(NUM_FU);
  localparam logic [LANE_W:0]  C_NUM_CDB = (LANE_W + 1)'(NUM_CDB);
  localparam logic [IDX_W-1:0] C_LAST_FU = IDX_W'(NUM_FU - 1);

  CDB_ENTRY [NUM_FU-1:0] w_head;
  logic [NUM_FU-1:0]     w_not_empty;
  logic [NUM_FU-1:0]     w_grant;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      w_start;
  logic [IDX_W-1:0]      w_last;
  logic                  w_any;
  logic [IDX_W:0]        w_sum;
  logic [IDX_W-1:0]      w_idx;
  logic [LANE_W:0]       w_lanes;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
    CDB_ENTRY w_push_data;

    assign w_push_data = '{tag:          fu_tag[gi],
                           value:        fu_value[gi],
                           branch_taken: fu_take_branch[gi]};

    cdb_fu_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .squash     (squash),
      .push_valid (fu_valid[gi]),
      .push_data  (w_push_data),
      .pop        (w_grant[gi]),
      .ready      (fu_ready[gi]),
      .not_empty  (w_not_empty[gi]),
      .head       (w_head[gi])
    );
  end

  assign w_start = (FIXED_PRIO != 0) ? '0 : r_rr_ptr;

  // Walk the FUs from w_start modulo NUM_FU, filling lanes in grant order.
  always_comb begin
    w_grant = '0;
    cdb_out = '0;
    w_last  = '0;
    w_any   = 1'b0;
    w_lanes = '0;
    w_sum   = '0;
    w_idx   = '0;
    if (!squash) begin
      for (int off = 0; off < NUM_FU; off++) begin
        w_sum = {1'b0, w_start} + (IDX_W + 1)'(off);
        if (w_sum >= C_NUM_FU) begin
          w_sum = w_sum - C_NUM_FU;
        end
        w_idx = w_sum[IDX_W-1:0];
        if (w_not_empty[w_idx] && (w_lanes < C_NUM_CDB)) begin
          w_grant[w_idx] = 1'b1;
          cdb_out[w_lanes[LANE_W-1:0]] = '{valid:        1'b1,
                                           clear:        1'b1,
                                           tag:          w_head[w_idx].tag,
                                           value:        w_head[w_idx].value,
                                           branch_taken: w_head[w_idx].branch_taken,
                                           fu_id:        FU_ID_W'(w_idx)};
          w_lanes = w_lanes + (LANE_W + 1)'(1);
          w_last  = w_idx;
          w_any   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (squash || (FIXED_PRIO != 0)) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (w_last == C_LAST_FU) ? '0 : w_last + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : scoreboard bench for a round-robin and a fixed-priority DUT
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
  import sys_defs::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic squash  = 1'b0;

  logic [4:0]               fu_valid       = '0;
  logic [4:0][TAG_SIZE-1:0] fu_tag         = '0;
  logic [4:0][XLEN-1:0]     fu_value       = '0;
  logic [4:0]               fu_take_branch = '0;
  logic [4:0]               fu_ready;
  CDB_OUTPUT [1:0]          cdb_out;

  logic                     fp_squash = 1'b0;
  logic [4:0]               fp_valid  = '0;
  logic [4:0][TAG_SIZE-1:0] fp_tag    = '0;
  logic [4:0][XLEN-1:0]     fp_value  = '0;
  logic [4:0]               fp_branch = '0;
  logic [4:0]               fp_ready;
  CDB_OUTPUT [0:0]          fp_cdb_out;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  exp_t q_main[$];
  exp_t q_fp[$];
  exp_t e_mon;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;

  cdb_arbiter u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .squash         (squash),
    .fu_valid       (fu_valid),
    .fu_tag         (fu_tag),
    .fu_value       (fu_value),
    .fu_take_branch (fu_take_branch),
    .fu_ready       (fu_ready),
    .cdb_out        (cdb_out)
  );

  cdb_arbiter #(
    .NUM_FU     (5),
    .NUM_CDB    (1),
    .FIFO_DEPTH (3),
    .FIXED_PRIO (1)
  ) u_fp (
    .clock          (clock),
    .reset_n        (reset_n),
    .squash         (fp_squash),
    .fu_valid       (fp_valid),
    .fu_tag         (fp_tag),
    .fu_value       (fp_value),
    .fu_take_branch (fp_branch),
    .fu_ready       (fp_ready),
    .cdb_out        (fp_cdb_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] lane64(input CDB_OUTPUT l);
    logic [63:0] r;
    r = '0;
    r[$bits(CDB_OUTPUT)-1:0] = l;
    return r;
  endfunction

  function automatic logic [63:0] mk_exp(input int fu, input int tag, input logic [31:0] val,
                                         input logic bt);
    CDB_OUTPUT e;
    e.valid        = 1'b1;
    e.clear        = 1'b1;
    e.tag          = TAG_SIZE'(tag);
    e.value        = val;
    e.branch_taken = bt;
    e.fu_id        = FU_ID_W'(fu);
    return lane64(e);
  endfunction

  function automatic logic [31:0] val_of(input int tag);
    return 32'hA000 + 32'(tag);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_main(input int fu, input int tag, input logic [31:0] val, input logic bt,
                          input int lat);
    q_main.push_back('{cyc: cyc + lat, data: mk_exp(fu, tag, val, bt)});
  endtask

  task automatic exp_fp(input int fu, input int tag, input int lat);
    q_fp.push_back('{cyc: cyc + lat, data: mk_exp(fu, tag, 32'hF000 + 32'(tag), 1'b0)});
  endtask

  task automatic drive_main(input int fu, input int tag, input logic bt);
    fu_valid[fu]       = 1'b1;
    fu_tag[fu]         = TAG_SIZE'(tag);
    fu_value[fu]       = val_of(tag);
    fu_take_branch[fu] = bt;
  endtask

  task automatic idle_main();
    fu_valid       = '0;
    fu_take_branch = '0;
  endtask

  // Lanes are popped from the scoreboard in lane order within each cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (cdb_out[k].valid) begin
          if (q_main.size() == 0) begin
            check("main_unexpected_bcast", lane64(cdb_out[k]), 64'd0);
          end else begin
            e_mon = q_main.pop_front();
            check("main_bcast_cycle", 64'(cyc), 64'(e_mon.cyc));
            check("main_bcast_lane", lane64(cdb_out[k]), e_mon.data);
          end
        end else begin
          check("main_idle_lane", lane64(cdb_out[k]), 64'd0);
        end
      end
      if (fp_cdb_out[0].valid) begin
        if (q_fp.size() == 0) begin
          check("fp_unexpected_bcast", lane64(fp_cdb_out[0]), 64'd0);
        end else begin
          e_mon = q_fp.pop_front();
          check("fp_bcast_cycle", 64'(cyc), 64'(e_mon.cyc));
          check("fp_bcast_lane", lane64(fp_cdb_out[0]), e_mon.data);
        end
      end else begin
        check("fp_idle_lane", lane64(fp_cdb_out[0]), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rdy_tab;

    // Reset state.
    repeat (2) tick();
    check("rst_ready_main", 64'(fu_ready), 64'h1f);
    check("rst_ready_fp", 64'(fp_ready), 64'h1f);
    check("rst_lane0", lane64(cdb_out[0]), 64'd0);
    check("rst_lane1", lane64(cdb_out[1]), 64'd0);
    check("rst_fp_lane", lane64(fp_cdb_out[0]), 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // All five FUs at once: {0,1}, {2,3}, {4}.
    tick();
    for (int i = 0; i < 5; i++) drive_main(i, 10 + i, (i == 4));
    exp_main(0, 10, val_of(10), 1'b0, 1);
    exp_main(1, 11, val_of(11), 1'b0, 1);
    exp_main(2, 12, val_of(12), 1'b0, 2);
    exp_main(3, 13, val_of(13), 1'b0, 2);
    exp_main(4, 14, val_of(14), 1'b1, 3);
    tick();
    idle_main();
    repeat (4) tick();
    check("burst_drained", 64'(q_main.size()), 64'd0);

    // Single result from FU 3 appears on lane 0 next cycle.
    tick();
    drive_main(3, 7, 1'b0);
    fu_value[3] = 32'h55;
    exp_main(3, 7, 32'h55, 1'b0, 1);
    tick();
    idle_main();
    @(negedge clock);
    check("single_lane1_zero", lane64(cdb_out[1]), 64'd0);
    check("single_lane0_valid", 64'(cdb_out[0].valid), 64'd1);
    repeat (3) tick();

    // rr_ptr now 4: search 4,0 first, then 1.
    tick();
    drive_main(0, 30, 1'b0);
    drive_main(1, 31, 1'b0);
    drive_main(4, 34, 1'b0);
    exp_main(4, 34, val_of(34), 1'b0, 1);
    exp_main(0, 30, val_of(30), 1'b0, 1);
    exp_main(1, 31, val_of(31), 1'b0, 2);
    tick();
    idle_main();
    repeat (3) tick();
    check("rr_drained", 64'(q_main.size()), 64'd0);

    // Streaming one FU: push and pop every cycle.
    for (int k = 0; k < 4; k++) begin
      tick();
      idle_main();
      drive_main(2, 40 + k, 1'b0);
      exp_main(2, 40 + k, val_of(40 + k), 1'b0, 1);
      check("stream_ready", 64'(fu_ready[2]), 64'd1);
    end
    tick();
    idle_main();
    repeat (3) tick();
    check("stream_drained", 64'(q_main.size()), 64'd0);

    // Squash: clear rr_ptr, fill, then flush with FU 4 holding two entries.
    tick();
    squash = 1'b1;
    tick();
    squash = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) drive_main(i, 50 + i, (i == 4));
    exp_main(0, 50, val_of(50), 1'b0, 1);
    exp_main(1, 51, val_of(51), 1'b0, 1);
    tick();
    check("sq_ready_pre", 64'(fu_ready), 64'h1f);
    for (int i = 0; i < 5; i++) drive_main(i, 60 + i, (i == 4));
    tick();
    check("sq_ready_full", 64'(fu_ready), 64'h03);
    for (int i = 0; i < 5; i++) drive_main(i, 20 + i, 1'b0);
    squash = 1'b1;
    @(negedge clock);
    check("sq_lanes_invalid", {62'd0, cdb_out[1].valid, cdb_out[0].valid}, 64'd0);
    tick();
    squash = 1'b0;
    idle_main();
    check("sq_ready_after", 64'(fu_ready), 64'h1f);
    repeat (5) tick();
    check("sq_nothing_left", 64'(q_main.size()), 64'd0);

    // Reset mid-burst, then an immediate enqueue after release.
    tick();
    for (int i = 0; i < 5; i++) drive_main(i, 80 + i, 1'b0);
    mon_en = 1'b0;
    tick();
    idle_main();
    check("rst_pre_valid", 64'(cdb_out[0].valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_lane0", lane64(cdb_out[0]), 64'd0);
    check("rst_mid_lane1", lane64(cdb_out[1]), 64'd0);
    check("rst_mid_ready", 64'(fu_ready), 64'h1f);
    tick();
    tick();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    drive_main(1, 9, 1'b0);
    exp_main(1, 9, val_of(9), 1'b0, 1);
    tick();
    idle_main();
    repeat (3) tick();
    check("rst_release_drained", 64'(q_main.size()), 64'd0);

    // Fixed priority, one lane, depth 3: FU 1 starves behind FU 0 and fills.
    rdy_tab = 8'b1110_0111;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin
        exp_fp(0, 1, 1);
        exp_fp(0, 2, 2);
        exp_fp(0, 3, 3);
        exp_fp(1, 21, 4);
        exp_fp(1, 22, 5);
        exp_fp(1, 23, 6);
        exp_fp(1, 24, 7);
      end
      fp_valid    = {3'b000, (c < 6), (c < 3)};
      fp_tag[0]   = TAG_SIZE'(1 + c);
      fp_value[0] = 32'hF000 + 32'(1 + c);
      fp_tag[1]   = (c < 3) ? TAG_SIZE'(21 + c) : TAG_SIZE'(24);
      fp_value[1] = 32'hF000 + 32'(fp_tag[1]);
      check("fp_ready1", 64'(fp_ready[1]), 64'(rdy_tab[c]));
    end
    tick();
    fp_valid = '0;
    repeat (3) tick();
    check("fp_starve_drained", 64'(q_fp.size()), 64'd0);

    // FU 0 tags 1..6 across the depth-3 pointer wrap.
    for (int k = 0; k < 6; k++) begin
      tick();
      fp_valid    = 5'b00001;
      fp_tag[0]   = TAG_SIZE'(1 + k);
      fp_value[0] = 32'hF000 + 32'(1 + k);
      exp_fp(0, 1 + k, 1);
    end
    tick();
    fp_valid = '0;
    repeat (3) tick();
    check("fp_wrap_drained", 64'(q_fp.size()), 64'd0);
    check("main_final_drained", 64'(q_main.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clock and reset_n.
REQ-002 The block SHALL take parameter NUM_FU, default 5, giving the number of functional-unit result sources.
REQ-003 The block SHALL take parameter NUM_CDB, default 2, giving the number of parallel broadcast lanes; legal range is 1..NUM_FU.
REQ-004 The block SHALL take parameter FIFO_DEPTH, default 2, giving the per-FU result buffer depth; it must be at least 1.
REQ-005 The block SHALL take parameter FIXED_PRIO, default 0; 0 selects round-robin and 1 selects fixed priority with the lowest FU index highest.
REQ-006 The block SHALL have the following ports, listed as name, direction, width and meaning:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- squash  in  1  mispredict flush.
- fu_valid  in  NUM_FU  result offered by the FU.
- fu_tag  in  NUM_FU x TAG_SIZE  destination tag.
- fu_value  in  NUM_FU x XLEN  result value.
- fu_take_branch  in  NUM_FU  branch outcome; meaningful only for the branch FU.
- fu_ready  out  NUM_FU  buffer can accept a result this cycle.
- cdb_out  out  NUM_CDB x CDB_OUTPUT  broadcast lanes, each carrying valid, clear, tag, value, branch_taken and fu_id.

Function
REQ-007 Enqueue SHALL occur at a rising edge when fu_valid[i] and fu_ready[i] are both high and squash is low; fu_valid while fu_ready is low is ignored, and the FU must hold the result.
REQ-008 fu_ready[i] SHALL equal (count[i] < FIFO_DEPTH) and SHALL NOT depend on the current-cycle grant, so a full buffer refuses input even when it is popped that cycle.
REQ-009 Each FU buffer SHALL be FIFO-ordered; head and tail pointers SHALL wrap from FIFO_DEPTH-1 to 0, with no power-of-two requirement.
REQ-010 Latency SHALL be one cycle minimum: a result enqueued at edge t is eligible for broadcast in the cycle following t, and there is no same-cycle bypass.
REQ-011 Each cycle, up to NUM_CDB non-empty buffers SHALL be granted, at most one entry per FU per cycle, namely its head entry.
REQ-012 In round-robin mode, the search SHALL start at rr_ptr and proceed in increasing index order modulo NUM_FU; the k-th granted FU drives lane k.
REQ-013 In round-robin mode, rr_ptr SHALL update at the edge to (last granted index + 1) mod NUM_FU, and SHALL be unchanged when nothing is granted.
REQ-014 In fixed-priority mode, the search SHALL always start at index 0 and rr_ptr SHALL be unused.
REQ-015 A granted lane SHALL carry the following fields:
- valid=1 and clear=1.
- tag and value from the head entry.
- branch_taken from the head entry.
- fu_id equal to the FU index.
REQ-016 Ungranted lanes SHALL drive all fields as 0.
REQ-017 cdb_out SHALL be combinational from the buffer heads and the grant; the granted heads SHALL be popped at the next edge.
REQ-018 When squash is high, all cdb_out lanes SHALL be driven invalid that cycle.
REQ-019 When squash is high, at the next edge all buffers SHALL empty, same-cycle enqueues SHALL be discarded, and rr_ptr SHALL reset to 0.
REQ-020 A simultaneous push and pop on a non-full buffer SHALL leave its count unchanged and preserve order.

Reset
REQ-021 While reset_n is low, all buffer counts and pointers and rr_ptr SHALL be 0, all cdb_out fields 0, and fu_ready all 1, asynchronously.
REQ-022 Reset deassertion mid-operation SHALL lose all buffered results, and the first enqueue SHALL be accepted at the first edge after deassertion.

Structure
REQ-023 The shared package (sys_defs) SHALL hold the following:
- the CDB_OUTPUT struct, with the fu_id field sized $clog2(NUM_FU_MAX).
- TAG_SIZE and XLEN.
- the NUM_FU, NUM_CDB and FIFO_DEPTH defaults.
REQ-024 The per-FU buffer SHALL be a sub-module, cdb_fu_fifo, instantiated NUM_FU times; arbitration and rr_ptr SHALL live in cdb_arbiter.

Verification
REQ-025 After reset, with fu_valid[3]=1, tag=7 and value=0x55 for one cycle, lane 0 SHALL show valid=1, tag=7, value=0x55 and fu_id=3 in the next cycle, and lane 1 SHALL be 0.
REQ-026 With all 5 FUs presenting one result each in the same cycle, NUM_CDB=2 and round-robin mode, the grants SHALL be FUs {0,1} on cycle 1, {2,3} on cycle 2 and {4} on cycle 3; each result appears exactly once.
REQ-027 With FIFO_DEPTH=2 and FU 1 pushing every cycle while no grants are possible (stub NUM_CDB lanes busy with higher FUs under FIXED_PRIO=1), fu_ready[1] SHALL drop after 2 accepted pushes and rise the cycle after a pop.
REQ-028 With FU 4 (branch) holding 2 entries and squash asserted, no lane SHALL be valid that cycle, all fu_ready SHALL be 1 afterwards, and nothing SHALL be broadcast later.
REQ-029 With FIFO_DEPTH=3, FU 0 pushing tags 1..6 and continuous grants, the tags SHALL be broadcast 1..6 in order with no loss across the pointer wrap.
REQ-030 With reset_n dropped mid-burst, the outputs SHALL go to 0 before the next edge and fu_ready SHALL be all 1.
